// File: rtl/lift_pkg.sv
// rtl/lift_pkg.sv - shared state/direction types and 7-segment glyphs for lift_ctrl
package lift_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVE_UP,
        ST_MOVE_DOWN,
        ST_DOOR_OPEN
    } state_t;

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } dir_t;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] GLYPH_UP    = 7'b1000001;
    localparam logic [6:0] GLYPH_DOWN  = 7'b0100001;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH_ESTOP = 7'b0000110;

endpackage

// File: rtl/hex7seg.sv
// rtl/hex7seg.sv - 4-bit decimal digit to active-low 7-segment {g,f,e,d,c,b,a}
module hex7seg (
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        unique case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/lift_ctrl.sv
// rtl/lift_ctrl.sv - SCAN lift controller; optional emergency stop under LIFT_ESTOP_EN
module lift_ctrl
    import lift_pkg::*;
#(
    parameter int N_FLOORS   = 9,
    parameter int TRAVEL_CYC = 50000000,
    parameter int DOOR_CYC   = 100000000,
    localparam int FW        = $clog2(N_FLOORS)
) (
    input  logic                clk,
    input  logic                res,
`ifdef LIFT_ESTOP_EN
    input  logic                estop,
`endif
    input  logic [N_FLOORS-1:0] sw,
    output logic [3:0]          LED_RED,
    output logic [3:0]          LED_GREEN,
    output logic [6:0]          HEX0,
    output logic [6:0]          HEX1,
    output logic [FW-1:0]       floor_o,
    output logic [N_FLOORS-1:0] pending_o
);

    localparam logic [31:0]   TRAVEL_LAST = 32'(TRAVEL_CYC - 1);
    localparam logic [31:0]   DOOR_LAST   = 32'(DOOR_CYC - 1);
    localparam logic [FW-1:0] TOP_FLOOR   = FW'(N_FLOORS - 1);

    state_t                state_q, state_d;
    dir_t                  dir_q, dir_d;
    logic [FW-1:0]         floor_q, floor_d, next_floor;
    logic [31:0]           cnt_q, cnt_d;
    logic [N_FLOORS-1:0]   pending_q, pending_d, sw_q, rise, clr;
    logic                  above, below, ahead, behind, run;

`ifdef LIFT_ESTOP_EN
    assign run = ~estop;
`else
    assign run = 1'b1;
`endif

    always_comb begin
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (i > int'(floor_q)) above = above | pending_q[i];
            if (i < int'(floor_q)) below = below | pending_q[i];
        end
    end

    always_comb begin
        next_floor = floor_q;
        if (state_q == ST_MOVE_UP && floor_q != TOP_FLOOR)
            next_floor = floor_q + 1'b1;
        else if (state_q == ST_MOVE_DOWN && floor_q != '0)
            next_floor = floor_q - 1'b1;
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        floor_d = floor_q;
        cnt_d   = cnt_q;
        rise    = sw & ~sw_q;
        clr     = '0;
        ahead   = (dir_q == DIR_UP) ? above : below;
        behind  = (dir_q == DIR_UP) ? below : above;
        // While frozen only request latching continues; everything else holds
        if (run) begin
            unique case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (pending_q[floor_q]) begin
                        state_d        = ST_DOOR_OPEN;
                        clr[floor_q]   = 1'b1;
                    end else if (above) begin
                        state_d = ST_MOVE_UP;
                        dir_d   = DIR_UP;
                    end else if (below) begin
                        state_d = ST_MOVE_DOWN;
                        dir_d   = DIR_DOWN;
                    end
                end
                ST_MOVE_UP, ST_MOVE_DOWN: begin
                    if (cnt_q == TRAVEL_LAST) begin
                        cnt_d   = '0;
                        floor_d = next_floor;
                        if (pending_q[next_floor]) begin
                            state_d         = ST_DOOR_OPEN;
                            clr[next_floor] = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                ST_DOOR_OPEN: begin
                    // A fresh press for the open floor keeps the door open instead of queueing
                    if (rise[floor_q]) begin
                        rise[floor_q] = 1'b0;
                        cnt_d         = '0;
                    end else if (cnt_q == DOOR_LAST) begin
                        cnt_d = '0;
                        if (ahead) begin
                            state_d = (dir_q == DIR_UP) ? ST_MOVE_UP : ST_MOVE_DOWN;
                        end else if (behind) begin
                            dir_d   = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
                            state_d = (dir_q == DIR_UP) ? ST_MOVE_DOWN : ST_MOVE_UP;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        pending_d = (pending_q | rise) & ~clr;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q   <= ST_IDLE;
            dir_q     <= DIR_UP;
            floor_q   <= '0;
            cnt_q     <= '0;
            pending_q <= '0;
            sw_q      <= sw;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            floor_q   <= floor_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            sw_q      <= sw;
        end
    end

    always_comb begin
        LED_GREEN = (state_q == ST_DOOR_OPEN) ? 4'hF : 4'h0;
        LED_RED   = (state_q == ST_DOOR_OPEN) ? 4'h0 : 4'hF;
        unique case (state_q)
            ST_MOVE_UP:   HEX1 = GLYPH_UP;
            ST_MOVE_DOWN: HEX1 = GLYPH_DOWN;
            default:      HEX1 = GLYPH_DASH;
        endcase
`ifdef LIFT_ESTOP_EN
        if (estop) HEX1 = GLYPH_ESTOP;
`endif
    end

    hex7seg u_hex0 (
        .digit (4'(floor_q)),
        .seg   (HEX0)
    );

    assign floor_o   = floor_q;
    assign pending_o = pending_q;

endmodule

// File: doc/lift_ctrl.md
LIFT_CTRL -- requirements
Module: lift_ctrl

Interface
REQ-001 Parameter N_FLOORS, default 9, number of served floors (2..10).
REQ-002 Parameter TRAVEL_CYC, default 50000000, clock cycles to travel one floor (>=1).
REQ-003 Parameter DOOR_CYC, default 100000000, clock cycles the door stays open (>=1).
REQ-004 Port clk  input  1  single system clock, all logic on rising edge.
REQ-005 Port res  input  1  reset, synchronous, active-high.
REQ-006 Port sw  input  N_FLOORS  floor-request switches, bit i = floor i.
REQ-007 Port LED_RED  output  4  all ones when the door is closed.
REQ-008 Port LED_GREEN  output  4  all ones when the door is open.
REQ-009 Port HEX0  output  7  current floor digit, active-low segments {g,f,e,d,c,b,a}.
REQ-010 Port HEX1  output  7  motion glyph, active-low segments.
REQ-011 Port floor_o  output  FW=$clog2(N_FLOORS)  current floor index.
REQ-012 Port pending_o  output  N_FLOORS  latched outstanding requests.

Function
REQ-013 sw registered once into sw_q; pending[i] sets on the edge after a cycle with sw[i]=1 and sw_q[i]=0; level-held switches generate no further requests.
REQ-014 FSM states IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN; direction register dir (UP/DOWN) kept across stops.
REQ-015 IDLE: pending bit for floor_o set -> DOOR_OPEN, bit cleared; else any pending above -> MOVE_UP; else any pending below -> MOVE_DOWN; else stay. Above is checked before below.
REQ-016 MOVE_x: travel counter counts TRAVEL_CYC cycles, then floor_o steps by +1/-1 and counter reloads; if pending[new floor] set -> DOOR_OPEN same edge, bit cleared.
REQ-017 DOOR_OPEN: door counter runs DOOR_CYC cycles; new rising request for floor_o restarts the counter and is not latched.
REQ-018 At door timeout (SCAN): pending ahead in dir -> continue in dir; else pending behind -> reverse; else IDLE.
REQ-019 floor_o never below 0 or above N_FLOORS-1; requests at switch bits >= N_FLOORS do not exist by width.
REQ-020 Arrival-clear and new request for the same floor on the same edge -> bit ends cleared (request served).
REQ-021 LED_GREEN=4'hF, LED_RED=4'h0 only in DOOR_OPEN; otherwise LED_GREEN=4'h0, LED_RED=4'hF.
REQ-022 HEX0 = decimal digit of floor_o (0=7'b1000000, 1=7'b1111001, ...).
REQ-023 HEX1: MOVE_UP 'U'=7'b1000001, MOVE_DOWN 'd'=7'b0100001, IDLE/DOOR_OPEN '-'=7'b0111111.
REQ-024 All outputs registered or decoded from registers; no combinational path from sw to any output.

Reset
REQ-025 res high at an edge: state IDLE, floor_o=0, dir=UP, pending_o=0, counters 0, sw_q=sw.
REQ-026 Reset values: LED_RED=4'hF, LED_GREEN=4'h0, HEX0=7'b1000000, HEX1=7'b0111111.
REQ-027 Reset mid-move or mid-door discards all pending requests in one cycle.

Configuration
REQ-028 Macro LIFT_ESTOP_EN defined: extra input estop (1 bit); while high, travel and door counters freeze, state and floor_o hold, HEX1=7'b0000110 ('E'), requests still latch; releasing resumes from the frozen count.
REQ-029 LIFT_ESTOP_EN undefined: no estop port, no freeze logic.

Structure
REQ-030 Package lift_pkg holds the state enum, direction enum, and HEX glyph constants.
REQ-031 Sub-module hex7seg (4-bit digit to active-low 7-segment) instantiated for HEX0.

Verification (N_FLOORS=9, TRAVEL_CYC=4, DOOR_CYC=3)
REQ-032 res=1 two cycles -> floor_o=0, pending_o=0, LED_RED=4'hF, HEX0=7'b1000000, HEX1=7'b0111111.
REQ-033 IDLE at 0, sw[3] rises -> MOVE_UP, HEX1='U', floor_o=3 after 12 cycles in MOVE_UP, LED_GREEN=4'hF for 3 cycles, then IDLE, pending_o=0.
REQ-034 Moving up at floor 2 with pending[5], sw[1] rises -> stops at 5 first, then reverses, stops at 1.
REQ-035 IDLE at 4, sw[4] rises -> DOOR_OPEN, floor_o stays 4, no MOVE state.
REQ-036 res asserted mid-travel between floors 2 and 3 with pending[7] -> next cycle floor_o=0, pending_o=0, IDLE.
REQ-037 (LIFT_ESTOP_EN) estop=1 for 10 cycles mid-travel -> floor_o and counter frozen, HEX1=7'b0000110; after release, arrival delayed by exactly 10 cycles.
